// File: rtl/clock_alarm_pkg.sv
// Shared types and BCD helpers for the
// alarm clock core.
package clock_alarm_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_H,
    SET_M,
    SET_S,
    AL_H,
    AL_M
  } state_e;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;

  function automatic logic [7:0] bcd_inc_wrap(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec_wrap(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // {pm, hh} for a 24h BCD hour shown in 12h form
  function automatic logic [8:0] to_12h(
    input logic [7:0] h
  );
    logic [6:0] b;
    logic [6:0] r;
    logic       p;
    b = 7'(h[7:4]) * 7'd10 + 7'(h[3:0]);
    p = (b >= 7'd12);
    if (b == 7'd0) r = 7'd12;
    else if (b > 7'd12) r = b - 7'd12;
    else r = b;
    if (r >= 7'd10) return {p, 4'd1, 4'(r - 7'd10)};
    return {p, 4'd0, 4'(r)};
  endfunction

endpackage

// File: rtl/clock_alarm_if.sv
// Button pulses, switches and display bus
// between the panel logic and the core.
interface clock_alarm_if;
  logic       up_pulse;
  logic       down_pulse;
  logic       center_pulse;
  logic       snooze_pulse;
  logic       alarm_en;
  logic       mode_12h;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic       pm;
  logic [2:0] edit_sel;
  logic       alarm_view;
  logic       ringing;
  logic       sec_pulse;

  modport master (
    output up_pulse, down_pulse, center_pulse,
    output snooze_pulse, alarm_en, mode_12h,
    input  hh_bcd, mm_bcd, ss_bcd, pm,
    input  edit_sel, alarm_view, ringing, sec_pulse
  );

  modport slave (
    input  up_pulse, down_pulse, center_pulse,
    input  snooze_pulse, alarm_en, mode_12h,
    output hh_bcd, mm_bcd, ss_bcd, pm,
    output edit_sel, alarm_view, ringing, sec_pulse
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping 00..MAX_BCD;
// carry flags an increment out of MAX_BCD.
module bcd_mod_counter
  import clock_alarm_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rst_val,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [7:0] q,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (reset) q <= rst_val;
    else if (clr) q <= 8'h00;
    else if (inc && !dec) q <= bcd_inc_wrap(q, MAX_BCD);
    else if (dec && !inc) q <= bcd_dec_wrap(q, MAX_BCD);
  end

  assign carry = inc && !dec && (q == MAX_BCD);

endmodule

// File: rtl/clock_alarm_core.sv
// BCD time-of-day core with settable alarm,
// snooze/dismiss, 12h display and edit FSM.
module clock_alarm_core
  import clock_alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned SNOOZE_MIN   = 5,
  parameter int unsigned RING_S       = 60,
  parameter logic [7:0]  ALARM_RST_HH = 8'h07
) (
  input logic          clk,
  input logic          reset,
  clock_alarm_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [11:0] SNZ_W = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]  RING_W = 8'(RING_S);

  state_e        state;
  logic [2:0]    edit_sel;
  logic          alarm_view;
  logic [PW-1:0] presc;
  logic [7:0]    ss, mm, hh, ahh, amm;
  logic          ss_c, mm_c;
  logic          hh_unused, ahh_unused, amm_unused;
  logic [7:0]    ring_cnt;
  logic [11:0]   snz_cnt;
  logic          ringing;
  logic          run_st, tick, up, dn, hit;
  logic [7:0]    mm_nx, hh_nx, hh_sel;
  logic [8:0]    h12;

  assign run_st = state inside {RUN, AL_H, AL_M};
  assign tick = run_st && (presc == PMAX);
  assign up = bus.up_pulse & ~bus.down_pulse;
  assign dn = bus.down_pulse & ~bus.up_pulse;

  always_ff @(posedge clk) begin
    if (reset || !run_st) presc <= '0;
    else if (presc == PMAX) presc <= '0;
    else presc <= presc + PW'(1);
  end

  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_ss (
    .clk(clk), .reset(reset), .rst_val(8'h00),
    .inc(tick), .dec(1'b0),
    .clr((state == SET_S) && (up || dn)),
    .q(ss), .carry(ss_c)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_mm (
    .clk(clk), .reset(reset), .rst_val(8'h00),
    .inc(ss_c || (state == SET_M && up)),
    .dec(state == SET_M && dn), .clr(1'b0),
    .q(mm), .carry(mm_c)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_23)) u_hh (
    .clk(clk), .reset(reset), .rst_val(8'h00),
    .inc((ss_c && mm_c) || (state == SET_H && up)),
    .dec(state == SET_H && dn), .clr(1'b0),
    .q(hh), .carry(hh_unused)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_23)) u_ahh (
    .clk(clk), .reset(reset), .rst_val(ALARM_RST_HH),
    .inc(state == AL_H && up),
    .dec(state == AL_H && dn), .clr(1'b0),
    .q(ahh), .carry(ahh_unused)
  );

  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_amm (
    .clk(clk), .reset(reset), .rst_val(8'h00),
    .inc(state == AL_M && up),
    .dec(state == AL_M && dn), .clr(1'b0),
    .q(amm), .carry(amm_unused)
  );

  // compare against the time this tick is about to produce
  assign mm_nx = bcd_inc_wrap(mm, BCD_59);
  assign hh_nx = (mm == BCD_59) ? bcd_inc_wrap(hh, BCD_23) : hh;
  assign hit = bus.alarm_en && ss_c &&
               (hh_nx == ahh) && (mm_nx == amm);

  always_ff @(posedge clk) begin
    if (reset) begin
      ringing  <= 1'b0;
      ring_cnt <= 8'd0;
      snz_cnt  <= 12'd0;
    end else if (!bus.alarm_en) begin
      ringing <= 1'b0;
      snz_cnt <= 12'd0;
    end else if (ringing && bus.center_pulse) begin
      ringing <= 1'b0;
      snz_cnt <= 12'd0;
    end else if (ringing && bus.snooze_pulse) begin
      ringing <= 1'b0;
      snz_cnt <= SNZ_W;
    end else if (hit || (tick && snz_cnt == 12'd1)) begin
      ringing  <= 1'b1;
      ring_cnt <= RING_W;
      snz_cnt  <= 12'd0;
    end else if (tick) begin
      if (snz_cnt != 12'd0) snz_cnt <= snz_cnt - 12'd1;
      if (ringing) begin
        ring_cnt <= ring_cnt - 8'd1;
        if (ring_cnt == 8'd1) ringing <= 1'b0;
      end
    end
  end

  // a dismiss press is consumed, so the FSM holds while ringing
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      edit_sel   <= 3'b000;
      alarm_view <= 1'b0;
    end else if (bus.center_pulse && !ringing) begin
      unique case (state)
        RUN: begin
          state <= SET_H; edit_sel <= 3'b100; alarm_view <= 1'b0;
        end
        SET_H: begin
          state <= SET_M; edit_sel <= 3'b010; alarm_view <= 1'b0;
        end
        SET_M: begin
          state <= SET_S; edit_sel <= 3'b001; alarm_view <= 1'b0;
        end
        SET_S: begin
          state <= AL_H; edit_sel <= 3'b100; alarm_view <= 1'b1;
        end
        AL_H: begin
          state <= AL_M; edit_sel <= 3'b010; alarm_view <= 1'b1;
        end
        default: begin
          state <= RUN; edit_sel <= 3'b000; alarm_view <= 1'b0;
        end
      endcase
    end
  end

  assign hh_sel = alarm_view ? ahh : hh;
  assign h12 = to_12h(hh_sel);

  assign bus.hh_bcd = bus.mode_12h ? h12[7:0] : hh_sel;
  assign bus.pm = bus.mode_12h & h12[8];
  assign bus.mm_bcd = alarm_view ? amm : mm;
  assign bus.ss_bcd = alarm_view ? 8'h00 : ss;
  assign bus.edit_sel = edit_sel;
  assign bus.alarm_view = alarm_view;
  assign bus.ringing = ringing;
  assign bus.sec_pulse = tick;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core with
// TICK_DIV=4, SNOOZE_MIN=1, RING_S=3.
module tb_clock_alarm_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  clock_alarm_if ifc();

  clock_alarm_core #(
    .TICK_DIV(4),
    .SNOOZE_MIN(1),
    .RING_S(3),
    .ALARM_RST_HH(8'h07)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         h;
    logic       mode;
    logic [7:0] exp_hh;
    logic       exp_pm;
  } vec_t;

  vec_t tbl [9];
  int checks = 0;
  int failures = 0;
  int ring_seen;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(
    input string name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(
    input string name,
    input logic act,
    input logic exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_time(
    input string name,
    input logic [7:0] h,
    input logic [7:0] m,
    input logic [7:0] s
  );
    chk8({name, "_hh"}, ifc.hh_bcd, h);
    chk8({name, "_mm"}, ifc.mm_bcd, m);
    chk8({name, "_ss"}, ifc.ss_bcd, s);
  endtask

  task automatic press(
    input logic u,
    input logic d,
    input logic c,
    input logic s
  );
    ifc.up_pulse = u;
    ifc.down_pulse = d;
    ifc.center_pulse = c;
    ifc.snooze_pulse = s;
    step();
    ifc.up_pulse = 1'b0;
    ifc.down_pulse = 1'b0;
    ifc.center_pulse = 1'b0;
    ifc.snooze_pulse = 1'b0;
  endtask

  task automatic up();  press(1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic dn();  press(1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic ctr(); press(1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic snz(); press(1'b0, 1'b0, 1'b0, 1'b1); endtask

  // consume n second ticks, each bounded
  task automatic run_secs(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      while (!ifc.sec_pulse && w < 8) begin
        step();
        w++;
      end
      if (!ifc.sec_pulse) begin
        checks++;
        failures++;
        $display("FAIL sec_pulse_timeout: none in 8 cycles");
        return;
      end
      step();
    end
  endtask

  // from RUN: edit hh:mm forward, clear ss, back to RUN
  task automatic set_hm(
    input int fh, input int fm,
    input int th, input int tm
  );
    ctr();
    repeat ((th - fh + 24) % 24) up();
    ctr();
    repeat ((tm - fm + 60) % 60) up();
    ctr();
    dn();
    ctr();
    ctr();
    ctr();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    tbl[0] = '{0,  1'b1, 8'h12, 1'b0};
    tbl[1] = '{1,  1'b1, 8'h01, 1'b0};
    tbl[2] = '{11, 1'b1, 8'h11, 1'b0};
    tbl[3] = '{12, 1'b1, 8'h12, 1'b1};
    tbl[4] = '{13, 1'b1, 8'h01, 1'b1};
    tbl[5] = '{23, 1'b1, 8'h11, 1'b1};
    tbl[6] = '{23, 1'b0, 8'h23, 1'b0};
    tbl[7] = '{12, 1'b0, 8'h12, 1'b0};
    tbl[8] = '{0,  1'b0, 8'h00, 1'b0};

    ifc.up_pulse = 1'b0;
    ifc.down_pulse = 1'b0;
    ifc.center_pulse = 1'b0;
    ifc.snooze_pulse = 1'b0;
    ifc.alarm_en = 1'b0;
    ifc.mode_12h = 1'b0;

    reset = 1'b1;
    step();
    step();
    chk_time("rst", 8'h00, 8'h00, 8'h00);
    chk8("rst_sel", {5'd0, ifc.edit_sel}, 8'h00);
    chk1("rst_av", ifc.alarm_view, 1'b0);
    chk1("rst_ring", ifc.ringing, 1'b0);
    chk1("rst_pulse", ifc.sec_pulse, 1'b0);
    chk1("rst_pm", ifc.pm, 1'b0);
    reset = 1'b0;

    ctr();
    chk8("seth_sel", {5'd0, ifc.edit_sel}, 8'h04);
    dn();
    chk8("hh_dn_wrap", ifc.hh_bcd, 8'h23);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    chk8("hh_updn", ifc.hh_bcd, 8'h23);
    up();
    chk8("hh_up_wrap", ifc.hh_bcd, 8'h00);

    cur = 0;
    for (int i = 0; i < 9; i++) begin
      repeat ((tbl[i].h - cur + 24) % 24) up();
      cur = tbl[i].h;
      ifc.mode_12h = tbl[i].mode;
      #1;
      chk8($sformatf("h12_%0d_hh", i), ifc.hh_bcd, tbl[i].exp_hh);
      chk1($sformatf("h12_%0d_pm", i), ifc.pm, tbl[i].exp_pm);
    end
    ifc.mode_12h = 1'b0;

    repeat (23) up();
    chk8("hh_23", ifc.hh_bcd, 8'h23);
    ctr();
    chk8("setm_sel", {5'd0, ifc.edit_sel}, 8'h02);
    repeat (59) up();
    chk_time("mm59", 8'h23, 8'h59, 8'h00);
    up();
    chk_time("mm_up_wrap", 8'h23, 8'h00, 8'h00);
    dn();
    chk8("mm_dn_wrap", ifc.mm_bcd, 8'h59);
    ctr();
    chk8("sets_sel", {5'd0, ifc.edit_sel}, 8'h01);
    ctr();
    chk_time("alh_view", 8'h07, 8'h00, 8'h00);
    chk1("alh_av", ifc.alarm_view, 1'b1);
    chk8("alh_sel", {5'd0, ifc.edit_sel}, 8'h04);
    ctr();
    chk8("alm_sel", {5'd0, ifc.edit_sel}, 8'h02);
    ctr();
    chk_time("run_2359", 8'h23, 8'h59, 8'h00);
    chk1("run_av", ifc.alarm_view, 1'b0);

    run_secs(30);
    chk_time("t30", 8'h23, 8'h59, 8'h30);
    run_secs(29);
    chk_time("t59", 8'h23, 8'h59, 8'h59);
    run_secs(1);
    chk_time("rollover", 8'h00, 8'h00, 8'h00);
    chk1("pulse_1cyc", ifc.sec_pulse, 1'b0);

    up();
    chk8("run_up_hh", ifc.hh_bcd, 8'h00);
    chk8("run_up_mm", ifc.mm_bcd, 8'h00);
    run_secs(5);
    chk8("ss05", ifc.ss_bcd, 8'h05);

    ctr();
    ctr();
    ctr();
    chk8("frz_ss", ifc.ss_bcd, 8'h05);
    repeat (10) step();
    chk8("frz_ss_hold", ifc.ss_bcd, 8'h05);
    chk1("frz_pulse", ifc.sec_pulse, 1'b0);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    chk8("ss_updn", ifc.ss_bcd, 8'h05);
    dn();
    chk8("ss_clr", ifc.ss_bcd, 8'h00);
    ctr();
    ctr();
    ctr();

    set_hm(0, 0, 6, 59);
    chk_time("set0659", 8'h06, 8'h59, 8'h00);
    run_secs(60);
    chk_time("dis_0700", 8'h07, 8'h00, 8'h00);
    chk1("dis_ring", ifc.ringing, 1'b0);

    set_hm(7, 0, 6, 59);
    ifc.alarm_en = 1'b1;
    run_secs(58);
    chk_time("en_0658", 8'h06, 8'h59, 8'h58);
    chk1("en_pre", ifc.ringing, 1'b0);
    run_secs(1);
    chk1("en_pre1", ifc.ringing, 1'b0);
    run_secs(1);
    chk_time("en_0700", 8'h07, 8'h00, 8'h00);
    chk1("ring_rise", ifc.ringing, 1'b1);
    run_secs(2);
    chk1("ring_hold", ifc.ringing, 1'b1);
    run_secs(1);
    chk1("ring_auto_stop", ifc.ringing, 1'b0);

    set_hm(7, 0, 6, 59);
    run_secs(60);
    chk1("ring2", ifc.ringing, 1'b1);
    snz();
    chk1("snz_off", ifc.ringing, 1'b0);
    run_secs(59);
    chk1("snz_59", ifc.ringing, 1'b0);
    run_secs(1);
    chk1("snz_rering", ifc.ringing, 1'b1);
    ctr();
    chk1("dismiss", ifc.ringing, 1'b0);
    chk8("dismiss_sel", {5'd0, ifc.edit_sel}, 8'h00);
    chk1("dismiss_av", ifc.alarm_view, 1'b0);
    snz();
    run_secs(61);
    chk1("no_rering", ifc.ringing, 1'b0);
    chk_time("t0702", 8'h07, 8'h02, 8'h01);

    set_hm(7, 2, 6, 59);
    run_secs(60);
    chk1("ring3", ifc.ringing, 1'b1);
    snz();
    chk1("snz3_off", ifc.ringing, 1'b0);
    run_secs(10);
    repeat (5) ctr();
    chk1("alm_av", ifc.alarm_view, 1'b1);
    chk8("alm_sel2", {5'd0, ifc.edit_sel}, 8'h02);
    reset = 1'b1;
    step();
    chk_time("rst2", 8'h00, 8'h00, 8'h00);
    chk8("rst2_sel", {5'd0, ifc.edit_sel}, 8'h00);
    chk1("rst2_av", ifc.alarm_view, 1'b0);
    chk1("rst2_ring", ifc.ringing, 1'b0);
    reset = 1'b0;

    ring_seen = 0;
    for (int i = 0; i < 70; i++) begin
      run_secs(1);
      if (ifc.ringing) ring_seen++;
    end
    chk8("ring_after_rst", 8'(ring_seen), 8'd0);

    repeat (4) ctr();
    chk8("al_rst_hh", ifc.hh_bcd, 8'h07);
    chk8("al_rst_mm", ifc.mm_bcd, 8'h00);
    ctr();
    up();
    chk8("al_mm_up", ifc.mm_bcd, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
